// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_pkg
//  Description : Shared types and helpers for consumers of a Johnson counter:
//                monitor FSM states, code legality, code-to-phase decode and
//                successor computation. Helpers take the register width as an
//                argument and operate on a zero-extended JC_MAXW-bit vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package johnson_pkg;

    // Widest Johnson register the helpers accept.
    localparam int JC_MAXW   = 32;
    // Default register width and its phase count.
    localparam int N_DEFAULT = 4;
    localparam int P         = 2 * N_DEFAULT;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FAULT    = 2'd3
    } jpm_state_e;

    // A Johnson code has at most one 0/1 boundary across its n bits.
    function automatic logic jc_is_legal(input logic [JC_MAXW-1:0] jc, input int n);
        int edges;
        edges = 0;
        for (int i = 1; i < JC_MAXW; i++) begin
            if ((i < n) && (jc[i] != jc[i-1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    // Phase index: ones count on the filling half, 2n minus ones on the draining half.
    function automatic int jc_to_idx(input logic [JC_MAXW-1:0] jc, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < JC_MAXW; i++) begin
            if ((i < n) && jc[i]) begin
                ones++;
            end
        end
        if (jc[n-1]) begin
            return (2 * n) - ones;
        end
        return ones;
    endfunction

    // Next code of the counter: shift left, feed back the inverted MSB.
    function automatic logic [JC_MAXW-1:0] jc_succ(input logic [JC_MAXW-1:0] jc, input int n);
        logic [JC_MAXW-1:0] mask;
        if (n >= JC_MAXW) begin
            mask = '1;
        end else begin
            mask = (JC_MAXW'(1) << n) - JC_MAXW'(1);
        end
        return ((jc << 1) | {{(JC_MAXW-1){1'b0}}, ~jc[n-1]}) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_phase_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_phase_monitor_if
//  Description : Sample input and decoded/health outputs of the Johnson phase
//                monitor. master = the side feeding codes and reading results,
//                slave = the monitor itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface johnson_phase_monitor_if #(
    parameter int N     = 4,
    parameter int LAP_W = 8
);
    localparam int IDX_W = $clog2(2 * N);

    logic                en;
    logic [N-1:0]        jc_in;
    logic [2*N-1:0]      phase_oh;
    logic [IDX_W-1:0]    phase_idx;
    logic                locked;
    logic                illegal;
    logic                seq_err;
    logic                lap_pulse;
    logic [LAP_W-1:0]    lap_cnt;
    logic                fault_sticky;

    modport master (
        output en, jc_in,
        input  phase_oh, phase_idx, locked, illegal, seq_err,
               lap_pulse, lap_cnt, fault_sticky
    );

    modport slave (
        input  en, jc_in,
        output phase_oh, phase_idx, locked, illegal, seq_err,
               lap_pulse, lap_cnt, fault_sticky
    );
endinterface
`default_nettype wire

// File: rtl/johnson_decode.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_decode
//  Description : Combinational Johnson code decoder: legality flag, binary
//                phase index and one-hot phase (zero for illegal codes).
//  Revision    : 1.0 - initial release
// ============================================================================
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic [N-1:0]               i_jc,
    output logic                            o_legal,
    output logic [$clog2(2*N)-1:0]          o_idx,
    output logic [2*N-1:0]                  o_onehot
);
    localparam int IDX_W = $clog2(2 * N);
    localparam int PW    = 2 * N;

    assign o_legal  = jc_is_legal(JC_MAXW'(i_jc), N);
    assign o_idx    = IDX_W'(jc_to_idx(JC_MAXW'(i_jc), N));
    assign o_onehot = o_legal ? (PW'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/johnson_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_phase_monitor
//  Description : Registers and decodes the Johnson counter state, checks code
//                legality and step sequence, tracks lock and counts laps.
//  Revision    : 1.0 - initial release
// ============================================================================
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int LOCK_CNT = 3,
    parameter int LAP_W    = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,      // active-low, synchronous
    johnson_phase_monitor_if.slave    bus
);
    localparam int IDX_W = $clog2(2 * N);
    localparam int PW    = 2 * N;

    // Code of the last phase (2N-1): MSB set, all others clear.
    localparam logic [N-1:0] C_LAST_CODE = {1'b1, {(N-1){1'b0}}};
    localparam logic [4:0]   C_LOCK_CNT  = 5'(LOCK_CNT);

    jpm_state_e         r_state;
    logic [N-1:0]       r_prev;
    logic [3:0]         r_good_cnt;
    logic [PW-1:0]      r_phase_oh;
    logic [IDX_W-1:0]   r_phase_idx;
    logic               r_locked;
    logic               r_illegal;
    logic               r_seq_err;
    logic               r_lap_pulse;
    logic [LAP_W-1:0]   r_lap_cnt;
    logic               r_fault_sticky;

    logic               w_legal;
    logic [IDX_W-1:0]   w_idx;
    logic [PW-1:0]      w_onehot;
    logic [N-1:0]       w_succ;
    logic               w_is_succ;
    logic               w_stall;
    logic               w_lap_step;
    logic [4:0]         w_cnt_inc;

    johnson_decode #(.N(N)) u_decode (
        .i_jc     (bus.jc_in),
        .o_legal  (w_legal),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_succ     = N'(jc_succ(JC_MAXW'(r_prev), N));
    assign w_is_succ  = (bus.jc_in == w_succ);
    assign w_stall    = (bus.jc_in == r_prev);
    assign w_lap_step = (r_prev == C_LAST_CODE) && (bus.jc_in == '0);
    assign w_cnt_inc  = {1'b0, r_good_cnt} + 5'd1;

    // Lock FSM, counters and all registered outputs, advanced once per en sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_UNLOCKED;
            r_prev         <= '0;
            r_good_cnt     <= '0;
            r_phase_oh     <= '0;
            r_phase_idx    <= '0;
            r_locked       <= 1'b0;
            r_illegal      <= 1'b0;
            r_seq_err      <= 1'b0;
            r_lap_pulse    <= 1'b0;
            r_lap_cnt      <= '0;
            r_fault_sticky <= 1'b0;
        end else begin
            r_illegal   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_lap_pulse <= 1'b0;
            if (bus.en) begin
                if (!w_legal) begin
                    // prev and phase_idx keep the last legal sample.
                    r_illegal      <= 1'b1;
                    r_fault_sticky <= 1'b1;
                    r_phase_oh     <= '0;
                    r_state        <= ST_FAULT;
                    r_locked       <= 1'b0;
                end else begin
                    r_phase_oh  <= w_onehot;
                    r_phase_idx <= w_idx;
                    r_prev      <= bus.jc_in;
                    case (r_state)
                        // Stall detection only applies once a reference code
                        // has been accepted, so a first 0000 after reset starts
                        // acquisition.
                        ST_UNLOCKED, ST_FAULT: begin
                            r_state    <= ST_ACQUIRE;
                            r_good_cnt <= 4'd1;
                        end
                        ST_ACQUIRE: begin
                            if (!w_stall) begin
                                if (w_is_succ) begin
                                    r_good_cnt <= w_cnt_inc[3:0];
                                    if (w_cnt_inc >= C_LOCK_CNT) begin
                                        r_state  <= ST_LOCKED;
                                        r_locked <= 1'b1;
                                    end
                                end else begin
                                    r_good_cnt <= 4'd1;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if (!w_stall) begin
                                if (w_is_succ) begin
                                    if (w_lap_step) begin
                                        r_lap_pulse <= 1'b1;
                                        r_lap_cnt   <= r_lap_cnt + LAP_W'(1);
                                    end
                                end else begin
                                    r_seq_err  <= 1'b1;
                                    r_state    <= ST_ACQUIRE;
                                    r_locked   <= 1'b0;
                                    r_good_cnt <= 4'd1;
                                end
                            end
                        end
                        default: begin
                            r_state <= ST_UNLOCKED;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.phase_oh     = r_phase_oh;
    assign bus.phase_idx    = r_phase_idx;
    assign bus.locked       = r_locked;
    assign bus.illegal      = r_illegal;
    assign bus.seq_err      = r_seq_err;
    assign bus.lap_pulse    = r_lap_pulse;
    assign bus.lap_cnt      = r_lap_cnt;
    assign bus.fault_sticky = r_fault_sticky;

endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_johnson_phase_monitor
//  Description : Self-checking bench for johnson_phase_monitor (N=4,
//                LOCK_CNT=3, LAP_W=8): vector table, directed corner
//                sequences and random stimulus against a phase-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_phase_monitor;
    localparam int N        = 4;
    localparam int P        = 8;
    localparam int LOCK_CNT = 3;
    localparam int LAP_W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    johnson_phase_monitor_if #(.N(N), .LAP_W(LAP_W)) bus_if ();

    johnson_phase_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .LAP_W(LAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Phase table: position in the array is the phase index.
    logic [3:0] codes [P] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    int n_pass  = 0;
    int n_total = 0;

    // Phase-level reference model.
    int         m_state;       // 0 unlocked, 1 acquire, 2 locked, 3 fault
    int         m_cnt;
    int         m_prev_idx;
    int         m_idx;
    int         m_laps;
    logic [7:0] m_oh;
    bit         m_locked, m_ill, m_seq, m_lap, m_sticky;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int code_pos(input logic [3:0] c);
        for (int i = 0; i < P; i++) begin
            if (codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [3:0] c);
        int  p;
        bit  stall, nxt;
        m_ill = 1'b0; m_seq = 1'b0; m_lap = 1'b0;
        if (!r) begin
            m_state = 0; m_cnt = 0; m_prev_idx = 0; m_idx = 0; m_laps = 0;
            m_oh = 8'h00; m_sticky = 1'b0;
        end else if (e) begin
            p = code_pos(c);
            if (p < 0) begin
                m_ill = 1'b1; m_sticky = 1'b1; m_oh = 8'h00; m_state = 3;
            end else begin
                m_oh  = 8'(1 << p);
                m_idx = p;
                stall = (p == m_prev_idx);
                nxt   = (p == (m_prev_idx + 1) % P);
                if (m_state == 0 || m_state == 3) begin
                    m_state = 1; m_cnt = 1;
                end else if (m_state == 1) begin
                    if (!stall) begin
                        if (nxt) begin
                            m_cnt++;
                            if (m_cnt >= LOCK_CNT) m_state = 2;
                        end else begin
                            m_cnt = 1;
                        end
                    end
                end else begin
                    if (!stall) begin
                        if (nxt) begin
                            if (m_prev_idx == P - 1) begin
                                m_lap = 1'b1;
                                m_laps = (m_laps + 1) % 256;
                            end
                        end else begin
                            m_seq = 1'b1; m_state = 1; m_cnt = 1;
                        end
                    end
                end
                m_prev_idx = p;
            end
        end
        m_locked = (m_state == 2);
    endtask

    task automatic compare_model(input string tag);
        chk({tag, " locked"},    32'(bus_if.locked),       32'(m_locked));
        chk({tag, " illegal"},   32'(bus_if.illegal),      32'(m_ill));
        chk({tag, " seq_err"},   32'(bus_if.seq_err),      32'(m_seq));
        chk({tag, " lap_pulse"}, 32'(bus_if.lap_pulse),    32'(m_lap));
        chk({tag, " phase_idx"}, 32'(bus_if.phase_idx),    32'(m_idx));
        chk({tag, " phase_oh"},  32'(bus_if.phase_oh),     32'(m_oh));
        chk({tag, " lap_cnt"},   32'(bus_if.lap_cnt),      32'(m_laps));
        chk({tag, " sticky"},    32'(bus_if.fault_sticky), 32'(m_sticky));
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] c, input string tag);
        rst          = r;
        bus_if.en    = e;
        bus_if.jc_in = c;
        @(posedge clk);
        #1;
        model_step(r, e, c);
        compare_model(tag);
    endtask

    typedef struct {
        bit         r;
        bit         e;
        logic [3:0] jc;
        bit         lk;
        bit         il;
        bit         se;
        bit         lp;
        int         idx;
        logic [7:0] oh;
        bit         st;
        int         lc;
    } vec_t;

    vec_t tbl [27];

    initial begin
        int   laps_seen;
        int   g_idx;
        bit   r, e;
        logic [3:0] c;
        int   ch;

        //          r  e  jc       lk il se lp idx oh     st lc
        tbl[0]  = '{0, 0, 4'b0000, 0, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 1, 4'b0000, 0, 0, 0, 0, 0, 8'h01, 0, 0};
        tbl[2]  = '{1, 1, 4'b0001, 0, 0, 0, 0, 1, 8'h02, 0, 0};
        tbl[3]  = '{1, 1, 4'b0011, 1, 0, 0, 0, 2, 8'h04, 0, 0};
        tbl[4]  = '{1, 1, 4'b0111, 1, 0, 0, 0, 3, 8'h08, 0, 0};
        tbl[5]  = '{1, 1, 4'b1111, 1, 0, 0, 0, 4, 8'h10, 0, 0};
        tbl[6]  = '{1, 1, 4'b1110, 1, 0, 0, 0, 5, 8'h20, 0, 0};
        tbl[7]  = '{1, 1, 4'b1100, 1, 0, 0, 0, 6, 8'h40, 0, 0};
        tbl[8]  = '{1, 1, 4'b1000, 1, 0, 0, 0, 7, 8'h80, 0, 0};
        tbl[9]  = '{1, 1, 4'b0000, 1, 0, 0, 1, 0, 8'h01, 0, 1};
        tbl[10] = '{1, 1, 4'b0001, 1, 0, 0, 0, 1, 8'h02, 0, 1};
        tbl[11] = '{1, 1, 4'b0011, 1, 0, 0, 0, 2, 8'h04, 0, 1};
        tbl[12] = '{1, 1, 4'b1110, 0, 0, 1, 0, 5, 8'h20, 0, 1};
        tbl[13] = '{1, 1, 4'b1100, 0, 0, 0, 0, 6, 8'h40, 0, 1};
        tbl[14] = '{1, 1, 4'b1000, 1, 0, 0, 0, 7, 8'h80, 0, 1};
        tbl[15] = '{1, 1, 4'b0000, 1, 0, 0, 1, 0, 8'h01, 0, 2};
        tbl[16] = '{1, 1, 4'b0101, 0, 1, 0, 0, 0, 8'h00, 1, 2};
        tbl[17] = '{1, 1, 4'b0001, 0, 0, 0, 0, 1, 8'h02, 1, 2};
        tbl[18] = '{1, 1, 4'b0011, 0, 0, 0, 0, 2, 8'h04, 1, 2};
        tbl[19] = '{1, 1, 4'b0111, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[20] = '{1, 0, 4'b0101, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[21] = '{1, 0, 4'b0101, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[22] = '{1, 0, 4'b1010, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[23] = '{1, 0, 4'b0000, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[24] = '{1, 0, 4'b1110, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[25] = '{1, 1, 4'b0111, 1, 0, 0, 0, 3, 8'h08, 1, 2};
        tbl[26] = '{1, 1, 4'b1111, 1, 0, 0, 0, 4, 8'h10, 1, 2};

        rst          = 1'b0;
        bus_if.en    = 1'b0;
        bus_if.jc_in = 4'b0000;

        // Vector table: lock-in, lap, sequence error, illegal code, en=0 hold.
        for (int i = 0; i < 27; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            step(tbl[i].r, tbl[i].e, tbl[i].jc, t);
            chk({t, " exp locked"},  32'(bus_if.locked),       32'(tbl[i].lk));
            chk({t, " exp illegal"}, 32'(bus_if.illegal),      32'(tbl[i].il));
            chk({t, " exp seq_err"}, 32'(bus_if.seq_err),      32'(tbl[i].se));
            chk({t, " exp lap"},     32'(bus_if.lap_pulse),    32'(tbl[i].lp));
            chk({t, " exp idx"},     32'(bus_if.phase_idx),    32'(tbl[i].idx));
            chk({t, " exp oh"},      32'(bus_if.phase_oh),     32'(tbl[i].oh));
            chk({t, " exp sticky"},  32'(bus_if.fault_sticky), 32'(tbl[i].st));
            chk({t, " exp lapcnt"},  32'(bus_if.lap_cnt),      32'(tbl[i].lc));
        end

        // Run on to lap_cnt=5, stop mid-lap at phase 3, then reset with en high.
        for (int j = 0; j < 23; j++) begin
            step(1'b1, 1'b1, codes[(5 + j) % P], $sformatf("run%0d", j));
        end
        chk("midreset pre lap_cnt", 32'(bus_if.lap_cnt), 32'd5);
        chk("midreset pre locked",  32'(bus_if.locked),  32'd1);
        step(1'b0, 1'b1, codes[4], "midreset");
        chk("midreset locked",  32'(bus_if.locked),       32'd0);
        chk("midreset lap_cnt", 32'(bus_if.lap_cnt),      32'd0);
        chk("midreset sticky",  32'(bus_if.fault_sticky), 32'd0);
        chk("midreset idx",     32'(bus_if.phase_idx),    32'd0);
        chk("midreset oh",      32'(bus_if.phase_oh),     32'd0);
        chk("midreset pulses",
            32'({bus_if.illegal, bus_if.seq_err, bus_if.lap_pulse}), 32'd0);

        // Lock, complete one lap, then 256 more: lap_cnt wraps back to 1.
        step(1'b1, 1'b1, codes[0], "wrap lock0");
        step(1'b1, 1'b1, codes[1], "wrap lock1");
        step(1'b1, 1'b1, codes[2], "wrap lock2");
        laps_seen = 0;
        for (int j = 0; j <= 5 + 256 * P; j++) begin
            step(1'b1, 1'b1, codes[(3 + j) % P], "wrap");
            if (bus_if.lap_pulse === 1'b1) laps_seen++;
            if (j == 5) chk("wrap first lap_cnt", 32'(bus_if.lap_cnt), 32'd1);
        end
        chk("wrap final lap_cnt", 32'(bus_if.lap_cnt), 32'd1);
        chk("wrap lap pulses",    32'(laps_seen),      32'd257);

        // Random stimulus: mostly forward steps, with stalls, jumps, bad codes,
        // en gaps and occasional resets.
        g_idx = 0;
        for (int j = 0; j < 3000; j++) begin
            ch = int'($urandom_range(0, 99));
            r  = ($urandom_range(0, 99) != 0);
            e  = ($urandom_range(0, 99) < 85);
            if (ch < 65)      c = codes[(g_idx + 1) % P];
            else if (ch < 75) c = codes[g_idx];
            else if (ch < 88) c = codes[$urandom_range(0, P - 1)];
            else              c = 4'($urandom_range(0, 15));
            step(r, e, c, $sformatf("rnd%0d", j));
            if (!r)                         g_idx = 0;
            else if (e && code_pos(c) >= 0) g_idx = code_pos(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
